// File: rtl/dsc_queue_ring_manager.sv
// dsc_queue_ring_manager
//   Per-queue descriptor ring manager. For each accepted metadata beat it
//   returns the ring slot to write (the tail before increment). It then
//   advances that queue's tail by UNIT and reports occupancy. A full ring
//   either drops the beat (FULL_MODE=0) or stalls the input (FULL_MODE=1).
//   Host head-pointer updates are accepted every cycle and forwarded into
//   the pipeline.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_*                metadata beat in (valid/ready handshake)
//   out_*               result beat out (valid/ready handshake)
//   head_wr_*           host head update, always accepted in RUN
//   rb_size             ring size in descriptor units (power of two)
module dsc_queue_ring_manager #(
  parameter int NB_QUEUES = 1024,
  parameter int QID_W     = $clog2(NB_QUEUES),
  parameter int PTR_W     = 26,
  parameter int META_W    = 64,
  parameter int UNIT      = 1,
  parameter int FULL_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [QID_W-1:0]  in_queue_id,
  input  logic              in_bypass,
  input  logic [META_W-1:0] in_meta,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [QID_W-1:0]  out_queue_id,
  output logic [PTR_W-1:0]  out_slot,
  output logic [PTR_W-1:0]  out_occupancy,
  output logic              out_drop,
  output logic              out_bypass,
  output logic [META_W-1:0] out_meta,
  input  logic              head_wr_valid,
  input  logic [QID_W-1:0]  head_wr_queue,
  input  logic [PTR_W-1:0]  head_wr_value,
  input  logic [PTR_W:0]    rb_size
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [PTR_W-1:0] UNIT_P = PTR_W'(UNIT);

  state_t             state_q, state_d;
  logic [QID_W-1:0]   clr_cnt_q;

  logic [PTR_W-1:0]   tail_mem [NB_QUEUES];
  logic [PTR_W-1:0]   head_mem [NB_QUEUES];

  logic               s1_valid;
  logic [QID_W-1:0]   s1_qid;
  logic               s1_bypass;
  logic [META_W-1:0]  s1_meta;
  logic [PTR_W-1:0]   s1_tail;
  logic [PTR_W-1:0]   s1_head;

  logic               run;
  logic [PTR_W-1:0]   mask;
  logic               head_wr_en;
  logic [PTR_W-1:0]   head_fwd;
  logic [PTR_W-1:0]   tail_sum;
  logic [PTR_W-1:0]   tail_new;
  logic               s1_full;
  logic               s1_block;
  logic               advance;
  logic               s1_fire;
  logic               tail_wr;
  logic               accept;
  logic [PTR_W-1:0]   occupancy;
  logic [PTR_W-1:0]   rd_tail;
  logic [PTR_W-1:0]   rd_head;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      if (state_q == ST_INIT) clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    state_d = state_q;
    if (state_q == ST_INIT && clr_cnt_q == QID_W'(NB_QUEUES - 1)) state_d = ST_RUN;
  end

  assign run        = (state_q == ST_RUN);
  assign head_wr_en = head_wr_valid && run;

  // --------------------------------------------------------- S1 compute
  assign mask     = PTR_W'(rb_size - (PTR_W+1)'(1));
  // A head update landing this cycle for the S1 queue takes precedence.
  assign head_fwd = (head_wr_en && head_wr_queue == s1_qid) ? head_wr_value : s1_head;
  assign tail_sum = s1_tail + UNIT_P;
  assign tail_new = tail_sum & mask;
  // Full when fewer than UNIT+1 slots are free; one slot always stays empty.
  assign s1_full  = s1_valid && !s1_bypass && (((tail_sum - head_fwd) & mask) < UNIT_P);
  assign s1_block = (FULL_MODE != 0) && s1_full;
  assign advance  = !out_valid || out_ready;
  assign s1_fire  = s1_valid && advance && !s1_block;
  assign tail_wr  = s1_fire && !s1_bypass && !s1_full;
  assign occupancy = s1_full ? ((s1_tail - head_fwd) & mask)
                             : ((tail_new - head_fwd) & mask);

  assign in_ready = run && (!s1_valid || s1_fire);
  assign accept   = in_valid && in_ready;

  // Table read with write-through: a tail written by S1 this cycle or a head
  // written by the host this cycle is what the new beat must see.
  assign rd_tail = (tail_wr && s1_qid == in_queue_id) ? tail_new : tail_mem[in_queue_id];
  assign rd_head = (head_wr_en && head_wr_queue == in_queue_id) ? head_wr_value
                                                                : head_mem[in_queue_id];

  // ------------------------------------------------------------- table
  // NOTE: the table has no reset; the INIT sweep clears it one entry per
  // cycle, which keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      tail_mem[clr_cnt_q] <= '0;
      head_mem[clr_cnt_q] <= '0;
    end else begin
      if (tail_wr)    tail_mem[s1_qid]        <= tail_new;
      if (head_wr_en) head_mem[head_wr_queue] <= head_wr_value;
    end
  end

  // ------------------------------------------------------------ S1 stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_qid    <= '0;
      s1_bypass <= 1'b0;
      s1_meta   <= '0;
      s1_tail   <= '0;
      s1_head   <= '0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_qid    <= in_queue_id;
      s1_bypass <= in_bypass;
      s1_meta   <= in_meta;
      s1_tail   <= rd_tail;
      s1_head   <= rd_head;
    end else if (s1_fire) begin
      s1_valid  <= 1'b0;
    end else if (head_wr_en && head_wr_queue == s1_qid) begin
      // A held beat keeps tracking host head updates for its queue.
      s1_head   <= head_wr_value;
    end
  end

  // ------------------------------------------------------ output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_queue_id  <= '0;
      out_slot      <= '0;
      out_occupancy <= '0;
      out_drop      <= 1'b0;
      out_bypass    <= 1'b0;
      out_meta      <= '0;
    end else if (s1_fire) begin
      out_valid     <= 1'b1;
      out_queue_id  <= s1_qid;
      out_bypass    <= s1_bypass;
      out_meta      <= s1_meta;
      out_drop      <= s1_full;
      out_slot      <= s1_bypass ? '0 : s1_tail;
      out_occupancy <= s1_bypass ? '0 : occupancy;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsc_queue_ring_manager.sv
// Testbench for dsc_queue_ring_manager. Three instances cover
// (UNIT=1, drop), (UNIT=1, stall) and (UNIT=2, drop); 'sel' routes the
// shared stimulus to one instance and muxes its outputs back.
module tb_dsc_queue_ring_manager;

  localparam int NQ   = 16;
  localparam int QW   = 4;
  localparam int PW   = 26;
  localparam int MW   = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    sel = 2'd0;
  logic          in_valid = 1'b0;
  logic [QW-1:0] in_queue_id = '0;
  logic          in_bypass = 1'b0;
  logic [MW-1:0] in_meta = '0;
  logic          out_ready = 1'b1;
  logic          head_wr_valid = 1'b0;
  logic [QW-1:0] head_wr_queue = '0;
  logic [PW-1:0] head_wr_value = '0;
  logic [PW:0]   rb_size = 27'd8;

  logic          d_in_valid [3];
  logic          d_head_wr_valid [3];
  logic          d_in_ready [3];
  logic          d_out_valid [3];
  logic [QW-1:0] d_out_qid [3];
  logic [PW-1:0] d_out_slot [3];
  logic [PW-1:0] d_out_occ [3];
  logic          d_out_drop [3];
  logic          d_out_bypass [3];
  logic [MW-1:0] d_out_meta [3];

  logic          o_in_ready, o_valid, o_drop, o_bypass;
  logic [QW-1:0] o_qid;
  logic [PW-1:0] o_slot, o_occ;
  logic [MW-1:0] o_meta;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      d_in_valid[k]      = in_valid && (sel == 2'(k));
      d_head_wr_valid[k] = head_wr_valid && (sel == 2'(k));
    end
    o_in_ready = d_in_ready[sel];
    o_valid    = d_out_valid[sel];
    o_qid      = d_out_qid[sel];
    o_slot     = d_out_slot[sel];
    o_occ      = d_out_occ[sel];
    o_drop     = d_out_drop[sel];
    o_bypass   = d_out_bypass[sel];
    o_meta     = d_out_meta[sel];
  end

  dsc_queue_ring_manager #(.NB_QUEUES(NQ), .PTR_W(PW), .META_W(MW), .UNIT(1), .FULL_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid[0]), .in_ready(d_in_ready[0]),
    .in_queue_id(in_queue_id), .in_bypass(in_bypass), .in_meta(in_meta),
    .out_valid(d_out_valid[0]), .out_ready(out_ready), .out_queue_id(d_out_qid[0]),
    .out_slot(d_out_slot[0]), .out_occupancy(d_out_occ[0]), .out_drop(d_out_drop[0]),
    .out_bypass(d_out_bypass[0]), .out_meta(d_out_meta[0]),
    .head_wr_valid(d_head_wr_valid[0]), .head_wr_queue(head_wr_queue),
    .head_wr_value(head_wr_value), .rb_size(rb_size));

  dsc_queue_ring_manager #(.NB_QUEUES(NQ), .PTR_W(PW), .META_W(MW), .UNIT(1), .FULL_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid[1]), .in_ready(d_in_ready[1]),
    .in_queue_id(in_queue_id), .in_bypass(in_bypass), .in_meta(in_meta),
    .out_valid(d_out_valid[1]), .out_ready(out_ready), .out_queue_id(d_out_qid[1]),
    .out_slot(d_out_slot[1]), .out_occupancy(d_out_occ[1]), .out_drop(d_out_drop[1]),
    .out_bypass(d_out_bypass[1]), .out_meta(d_out_meta[1]),
    .head_wr_valid(d_head_wr_valid[1]), .head_wr_queue(head_wr_queue),
    .head_wr_value(head_wr_value), .rb_size(rb_size));

  dsc_queue_ring_manager #(.NB_QUEUES(NQ), .PTR_W(PW), .META_W(MW), .UNIT(2), .FULL_MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid[2]), .in_ready(d_in_ready[2]),
    .in_queue_id(in_queue_id), .in_bypass(in_bypass), .in_meta(in_meta),
    .out_valid(d_out_valid[2]), .out_ready(out_ready), .out_queue_id(d_out_qid[2]),
    .out_slot(d_out_slot[2]), .out_occupancy(d_out_occ[2]), .out_drop(d_out_drop[2]),
    .out_bypass(d_out_bypass[2]), .out_meta(d_out_meta[2]),
    .head_wr_valid(d_head_wr_valid[2]), .head_wr_queue(head_wr_queue),
    .head_wr_value(head_wr_value), .rb_size(rb_size));

  // ------------------------------------------------------------ checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [QW-1:0] qid;
    logic [PW-1:0] slot;
    logic [PW-1:0] occ;
    logic          drop;
    logic          bypass;
    logic [MW-1:0] meta;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   cyc = 0;

  always @(posedge clk) cyc++;

  // Scoreboard monitor: samples on the falling edge, pops on handshake and
  // checks that a stalled output holds its value into the next cycle.
  logic          stalled = 1'b0;
  logic [PW-1:0] held_slot;
  logic [MW-1:0] held_meta;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled && o_valid) begin
        check("hold_slot", o_slot, held_slot);
        check("hold_meta", o_meta, held_meta);
      end
      stalled = 1'b0;
      if (o_valid && out_ready) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("out_qid",    o_qid,    mon_e.qid);
          check("out_slot",   o_slot,   mon_e.slot);
          check("out_occ",    o_occ,    mon_e.occ);
          check("out_drop",   o_drop,   mon_e.drop);
          check("out_bypass", o_bypass, mon_e.bypass);
          check("out_meta",   o_meta,   mon_e.meta);
          pop_cyc.push_back(cyc);
        end
      end else if (o_valid) begin
        stalled   = 1'b1;
        held_slot = o_slot;
        held_meta = o_meta;
      end
    end
  end

  // --------------------------------------------------------------- tasks
  task automatic expect_beat(input int q, input int slot, input int occ,
                             input logic drop, input logic byp, input logic [MW-1:0] meta);
    exp_t e;
    e.qid = QW'(q); e.slot = PW'(slot); e.occ = PW'(occ);
    e.drop = drop; e.bypass = byp; e.meta = meta;
    exp_q.push_back(e);
  endtask

  // Presents one beat (entered at posedge+1) and returns at posedge+1 after
  // it is accepted, leaving in_valid high for back-to-back use.
  task automatic drive(input int q, input logic byp, input logic [MW-1:0] meta);
    logic accepted;
    accepted    = 1'b0;
    in_valid    = 1'b1;
    in_queue_id = QW'(q);
    in_bypass   = byp;
    in_meta     = meta;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    check("accept", accepted, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_bypass = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic head_write(input int q, input int v);
    head_wr_valid = 1'b1;
    head_wr_queue = QW'(q);
    head_wr_value = PW'(v);
    @(posedge clk);
    #1;
    head_wr_valid = 1'b0;
  endtask

  // Resets, checks reset outputs, and returns once INIT has finished,
  // reporting how many cycles in_ready stayed low.
  task automatic reset_dut(input logic [1:0] s, input int rb, output int init_cycles);
    sel = s;
    @(posedge clk);
    #1;
    idle();
    head_wr_valid = 1'b0;
    out_ready = 1'b1;
    rb_size = (PW+1)'(rb);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_out_valid", o_valid, 0);
    check("rst_in_ready", o_in_ready, 0);
    check("rst_slot", o_slot, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    init_cycles = 0;
    for (int i = 0; i < NQ + 20; i++) begin
      @(negedge clk);
      if (o_in_ready) break;
      init_cycles++;
    end
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------ stimulus
  int init_cycles;

  initial begin
    // Test 1: INIT length, first beat latency and result.
    reset_dut(2'd0, 8, init_cycles);
    check("init_cycles", init_cycles, NQ);
    check("ready_run", o_in_ready, 1);
    expect_beat(3, 0, 1, 0, 0, 64'h1111);
    drive(3, 0, 64'h1111);
    idle();
    @(negedge clk);
    check("lat_cycle1", o_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_cycle2", o_valid, 1);
    wait_drain();

    // Test 2: back-to-back beats to one queue, no bubbles.
    pop_cyc.delete();
    for (int i = 0; i < 4; i++) expect_beat(5, i, i + 1, 0, 0, 64'h500 + 64'(i));
    for (int i = 0; i < 4; i++) drive(5, 0, 64'h500 + 64'(i));
    idle();
    wait_drain();
    check("b2b_count", pop_cyc.size(), 4);
    for (int i = 0; i + 1 < pop_cyc.size(); i++) check("no_bubble", pop_cyc[i+1] - pop_cyc[i], 1);

    // Test 3: drop on full, then host head update frees space.
    reset_dut(2'd0, 4, init_cycles);
    expect_beat(1, 0, 1, 0, 0, 64'h10);
    expect_beat(1, 1, 2, 0, 0, 64'h11);
    expect_beat(1, 2, 3, 0, 0, 64'h12);
    expect_beat(1, 3, 3, 1, 0, 64'h13);
    for (int i = 0; i < 4; i++) drive(1, 0, 64'h10 + 64'(i));
    idle();
    wait_drain();
    head_write(1, 2);
    expect_beat(1, 3, 2, 0, 0, 64'h14);
    drive(1, 0, 64'h14);
    idle();
    wait_drain();

    // Test 4: stall on full, released by a host head update.
    reset_dut(2'd1, 4, init_cycles);
    expect_beat(1, 0, 1, 0, 0, 64'h20);
    expect_beat(1, 1, 2, 0, 0, 64'h21);
    expect_beat(1, 2, 3, 0, 0, 64'h22);
    expect_beat(1, 3, 3, 0, 0, 64'h23);
    for (int i = 0; i < 4; i++) drive(1, 0, 64'h20 + 64'(i));
    idle();
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", o_in_ready, 0);
    end
    check("stall_pending", exp_q.size(), 1);
    @(posedge clk);
    #1;
    head_write(1, 1);
    wait_drain();
    check("stall_released", o_in_ready, 1);

    // Test 5: UNIT=2 with wrap, head advanced by host.
    reset_dut(2'd2, 8, init_cycles);
    expect_beat(7, 0, 2, 0, 0, 64'h70);
    expect_beat(7, 2, 4, 0, 0, 64'h71);
    expect_beat(7, 4, 6, 0, 0, 64'h72);
    expect_beat(7, 6, 6, 1, 0, 64'h73);
    for (int i = 0; i < 4; i++) drive(7, 0, 64'h70 + 64'(i));
    idle();
    wait_drain();
    head_write(7, 6);
    expect_beat(7, 6, 2, 0, 0, 64'h74);
    drive(7, 0, 64'h74);
    idle();
    wait_drain();
    head_write(7, 0);
    expect_beat(7, 0, 2, 0, 0, 64'h75);
    drive(7, 0, 64'h75);
    idle();
    wait_drain();

    // Test 6: bypass interleaved with out_ready toggling.
    reset_dut(2'd0, 8, init_cycles);
    expect_beat(2, 0, 1, 0, 0, 64'hA0);
    expect_beat(9, 0, 0, 0, 1, 64'hB0);
    expect_beat(2, 1, 2, 0, 0, 64'hC0);
    fork
      begin
        drive(2, 0, 64'hA0);
        drive(9, 1, 64'hB0);
        drive(2, 0, 64'hC0);
        idle();
      end
      begin
        logic rdy_pat [4];
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
          out_ready = rdy_pat[i];
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset mid-stream: in-flight beats vanish, table re-initialises.
    out_ready = 1'b0;
    drive(2, 0, 64'hD0);
    drive(2, 0, 64'hD1);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_valid", o_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_ready", o_in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    init_cycles = 0;
    for (int i = 0; i < NQ + 20; i++) begin
      @(negedge clk);
      if (o_in_ready) break;
      init_cycles++;
    end
    check("reinit_cycles", init_cycles, NQ);
    repeat (4) @(posedge clk);
    #1;
    expect_beat(2, 0, 1, 0, 0, 64'hE0);
    drive(2, 0, 64'hE0);
    idle();
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dsc_queue_ring_manager.md
Name: dsc_queue_ring_manager

Overview:
- Next-generation descriptor queue manager with an internal per-queue tail/head table and generalised ring arithmetic.
- Sits between the packet-to-queue mapper and the descriptor DMA writer.
- For each metadata beat it returns the descriptor-ring slot to write. It advances the tail by a configurable unit and detects full rings, dropping or back-pressuring according to FULL_MODE.
- Accepts host head-pointer updates concurrently, with forwarding.

Parameters:
- NB_QUEUES, 1024: number of descriptor queues; power of two, ≥2.
- QID_W, $clog2(NB_QUEUES): queue-id width.
- PTR_W, 26: ring-pointer width, in descriptor units.
- META_W, 64: opaque pass-through metadata width.
- UNIT, 1: tail advance per accepted non-bypass beat; 1..8.
- FULL_MODE, 0: 0 = drop on full (out_drop=1, tail unchanged); 1 = stall input until the ring has space.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when valid&ready
- in_queue_id  in  QID_W  target descriptor queue
- in_bypass  in  1  beat needs no descriptor; no table access
- in_meta  in  META_W  pass-through metadata
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_queue_id  out  QID_W  echoed queue id
- out_slot  out  PTR_W  tail before increment (descriptor write slot)
- out_occupancy  out  PTR_W  (tail_new - head) & mask, after this beat
- out_drop  out  1  ring full, beat dropped (FULL_MODE=0 only)
- out_bypass  out  1  echoed in_bypass
- out_meta  out  META_W  echoed metadata
- head_wr_valid  in  1  host head update; always accepted
- head_wr_queue  in  QID_W  queue for head update
- head_wr_value  in  PTR_W  new head value
- rb_size  in  PTR_W+1  ring size in units; power of two, 2..2^PTR_W; static while in RUN

Behaviour:
- Reset (rst_n=0, async):
  - in_ready=0, out_valid=0; out_slot, out_occupancy, out_queue_id, out_meta=0; out_drop=0, out_bypass=0.
  - FSM goes to INIT and the pipeline is flushed.
- FSM INIT:
  - Clear counter sweeps 0..NB_QUEUES-1, writing tail=0 and head=0, one entry per cycle. Takes NB_QUEUES cycles.
  - in_ready=0 throughout; head_wr beats in INIT are ignored.
  - Then go to RUN.
- FSM RUN:
  - in_ready = !s1_valid | advance, where advance = !out_valid | out_ready.
  - In FULL_MODE=1, additionally in_ready=0 while s1 holds a full-ring beat.
- Pipeline:
  - S0 accept: table read issued with 1-cycle read latency.
  - S1: compute.
  - Output register: out_valid asserts 2 cycles after acceptance when there is no stall.
  - Sustained throughput is 1 beat/cycle.
- Arithmetic:
  - mask = rb_size - 1.
  - tail_new = (tail + UNIT) & mask.
  - full when ((tail + UNIT) - head) & mask < UNIT, i.e. fewer than UNIT+1 free slots.
  - One slot is always kept empty, so tail==head means empty.
- Full ring:
  - FULL_MODE=0: out_drop=1, out_slot=current tail, no table write.
  - FULL_MODE=1: the beat holds in S1 and re-evaluates each cycle against the forwarded head until not full. There is no drop.
- Bypass beats:
  - out_bypass=1, out_slot=0, out_occupancy=0, out_drop=0, no table write.
  - They still keep order with other beats.
- Forwarding:
  - A tail written by S1 in cycle N must be seen by a lookup of the same queue read in cycle N. Back-to-back beats to the same queue get consecutive slots.
  - A head_wr landing in the same cycle as the S1 compute for that queue: S1 uses head_wr_value.
  - A head_wr in the same cycle as the S0 read: the write wins.
- Output stall: when out_valid & !out_ready, all outputs hold stable and S1 does not advance.
- Wrap: tail = mask with UNIT=1 yields slot mask, then tail_new=0.
- Reset mid-operation: in-flight beats are discarded and never emitted; the table re-initialises via INIT.

Test Plan:
- Reset, then wait NB_QUEUES cycles: in_ready=0 during INIT and 1 afterwards. Then send q=3 with rb_size=8, UNIT=1: out_slot=0, occupancy=1, latency 2 cycles.
- 4 back-to-back beats to q=5 with rb_size=8: out_slot=0,1,2,3; occupancy 1..4; no bubbles with out_ready=1.
- FULL_MODE=0, rb_size=4, 4 beats to q=1: slots 0,1,2, then the 4th has out_drop=1 with slot 3. Then head_wr q=1 value=2; next beat: slot 3, drop=0, occupancy=2.
- FULL_MODE=1, same fill: the 4th beat stalls with in_ready=0. head_wr q=1 value=1 releases it: slot 3, drop=0.
- Wrap with UNIT=2, rb_size=8, head advanced by host: slots 0,2,4, then head=6, slot 6, then head wraps to 0 and slot 0.
- Interleave: bypass beat between q=2 beats while out_ready toggles 1,0,0,1. Required: order kept, bypass has slot=0, outputs stable while stalled. Assert rst_n mid-stream: out_valid=0 immediately, then INIT.
